// File: rtl/hdb3_pkg.sv
// hdb3_pkg: symbol encodings, polarity type and default parameters shared by
// the HDB3 encoder chain and the hdb3_decode receiver.
package hdb3_pkg;

  // Ternary symbol encoding on the 2-bit line interface
  localparam logic [1:0] CODE_ZERO = 2'b00;
  localparam logic [1:0] CODE_POS  = 2'b01;
  localparam logic [1:0] CODE_NEG  = 2'b10;
  localparam logic [1:0] CODE_ILL  = 2'b11;

  // V plus the three positions it may replace
  localparam int HDB3_LATENCY      = 4;
  localparam int HDB3_ZERO_RUN_MAX = 3;

  typedef enum logic [1:0] {
    POL_NONE = 2'd0,
    POL_POS  = 2'd1,
    POL_NEG  = 2'd2
  } pol_e;

  // Polarity carried by a symbol; zero and illegal symbols carry none.
  function automatic pol_e code_pol(input logic [1:0] code);
    case (code)
      CODE_POS: code_pol = POL_POS;
      CODE_NEG: code_pol = POL_NEG;
      default:  code_pol = POL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/hdb3_v_detect.sv
// hdb3_v_detect: per-symbol classifier for the HDB3 receiver.
// Tracks pulse polarity, last-V polarity and the zero-run length, and reports
// for the symbol currently on i_code (combinationally):
//   o_mark  - symbol is a pulse (nonzero, legal)
//   o_is_v  - pulse repeats the polarity of the previous pulse (violation)
//   o_err   - illegal symbol, over-long zero run, or V with same polarity
//             as the previous V
// Ports: i_clk, i_rst_n (async active-low), i_code[1:0], o_mark, o_is_v, o_err.
module hdb3_v_detect
  import hdb3_pkg::*;
#(
  parameter int ZERO_RUN_MAX = HDB3_ZERO_RUN_MAX
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [1:0] i_code,
  output logic       o_mark,
  output logic       o_is_v,
  output logic       o_err
);

  localparam int ZCNT_W = $clog2(ZERO_RUN_MAX + 2);
  localparam logic [ZCNT_W-1:0] ZCNT_MAX = ZCNT_W'(ZERO_RUN_MAX);
  localparam logic [ZCNT_W-1:0] ZCNT_SAT = ZCNT_W'(ZERO_RUN_MAX + 1);

  pol_e              pol_q, pol_d;
  pol_e              last_v_q, last_v_d;
  logic [ZCNT_W-1:0] zcnt_q, zcnt_d;

  pol_e sym_pol;
  logic run_err, alt_err, ill_err;

  always_comb begin
    sym_pol  = code_pol(i_code);
    o_mark   = (sym_pol != POL_NONE);
    // The first pulse after reset sees POL_NONE and can never be a V.
    o_is_v   = o_mark && (pol_q != POL_NONE) && (sym_pol == pol_q);
    pol_d    = o_mark ? sym_pol : pol_q;
    last_v_d = o_is_v ? sym_pol : last_v_q;

    // Saturating counter; the error fires only on the 3->4 step, so a long
    // run of zeros reports once until a pulse clears it.
    zcnt_d = zcnt_q;
    if (o_mark)                zcnt_d = '0;
    else if (zcnt_q != ZCNT_SAT) zcnt_d = zcnt_q + 1'b1;

    run_err = !o_mark && (zcnt_q == ZCNT_MAX);
    // last_v_q == POL_NONE never matches, which exempts the first V.
    alt_err = o_is_v && (sym_pol == last_v_q);
    ill_err = (i_code == CODE_ILL);
    o_err   = run_err | alt_err | ill_err;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pol_q    <= POL_NONE;
      last_v_q <= POL_NONE;
      zcnt_q   <= '0;
    end else begin
      pol_q    <= pol_d;
      last_v_q <= last_v_d;
      zcnt_q   <= zcnt_d;
    end
  end

endmodule

// File: rtl/hdb3_decode.sv
// hdb3_decode: HDB3 line decoder. Removes 000V / B00V substitutions from the
// ternary symbol stream and recovers the NRZ data, flagging V pulses and
// line-code errors.
// Ports: i_clk, i_rst_n (async active-low), i_hdb3_code[1:0] ternary symbol,
//   o_data   recovered bit, LATENCY edges after its symbol,
//   o_v_det  pulse, V seen in the symbol sampled one edge earlier,
//   o_code_err pulse, code error in the symbol sampled one edge earlier.
module hdb3_decode
  import hdb3_pkg::*;
#(
  parameter int LATENCY      = HDB3_LATENCY,
  parameter int ZERO_RUN_MAX = HDB3_ZERO_RUN_MAX
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [1:0] i_hdb3_code,
  output logic       o_data,
  output logic       o_v_det,
  output logic       o_code_err
);

  logic mark, is_v, err;

  hdb3_v_detect #(.ZERO_RUN_MAX(ZERO_RUN_MAX)) u_v_detect (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_code  (i_hdb3_code),
    .o_mark  (mark),
    .o_is_v  (is_v),
    .o_err   (err)
  );

  // dl[0] newest .. dl[LATENCY-1] oldest mark
  logic [LATENCY-1:0] dl_q, dl_d;
  logic               data_q, data_d;
  // Status pipes: [0] holds the flag for the symbol just taken, [1] drives the port
  logic [1:0]         v_pipe_q, v_pipe_d;
  logic [1:0]         err_pipe_q, err_pipe_d;

  always_comb begin
    data_d = dl_q[LATENCY-1];
    // A V wipes itself and the three positions before it, covering both
    // 000V and B00V; the oldest entry still leaves normally via data_d.
    dl_d       = is_v ? '0 : {dl_q[LATENCY-2:0], mark};
    v_pipe_d   = {v_pipe_q[0], is_v};
    err_pipe_d = {err_pipe_q[0], err};
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      dl_q       <= '0;
      data_q     <= 1'b0;
      v_pipe_q   <= '0;
      err_pipe_q <= '0;
    end else begin
      dl_q       <= dl_d;
      data_q     <= data_d;
      v_pipe_q   <= v_pipe_d;
      err_pipe_q <= err_pipe_d;
    end
  end

  assign o_data     = data_q;
  assign o_v_det    = v_pipe_q[1];
  assign o_code_err = err_pipe_q[1];

endmodule

// File: doc/hdb3_decode.md
Name: hdb3_decode

Overview:
- Receive-side partner of the HDB3 encoder chain.
- Consumes the 2-bit ternary symbol stream that the encoder's final stage (dual-to-ternary) produces, at one symbol per clock.
- Detects V (violation) pulses, removes the 000V / B00V substitutions, and recovers the original NRZ bit stream.
- Flags line-code errors: illegal symbol, zero run longer than 3, non-alternating V polarity.

Parameters:
- LATENCY, 4, symbol-to-data pipeline depth. Fixed by HDB3 (V plus 3 preceding positions); only the value 4 is supported.
- ZERO_RUN_MAX, 3, longest legal run of consecutive zero symbols.

Ports:
- i_clk  input  1  symbol clock, rising edge.
- i_rst_n  input  1  asynchronous, active-low reset.
- i_hdb3_code  input  2  ternary symbol: 2'b00 = 0, 2'b01 = +1, 2'b10 = -1, 2'b11 = illegal.
- o_data  output  1  recovered NRZ bit, registered.
- o_v_det  output  1  one-cycle pulse: a V symbol was sampled on the previous edge.
- o_code_err  output  1  one-cycle pulse: a code error was found in the symbol sampled on the previous edge.

Behaviour:
- Reset is asynchronous and active-low on i_rst_n, single clock i_clk.
- Reset values: o_data=0, o_v_det=0, o_code_err=0, delay line all 0, polarity state NONE, last-V state NONE, zero counter 0.
- Input handling: one symbol sampled every rising edge; there is no valid/ready. An illegal symbol (11) is treated as 0 for decoding and for the polarity/zero-run logic.
- Mark bit: a symbol is a mark if it is nonzero.
- Pulse-polarity FSM, states NONE / POS / NEG:
  - A nonzero symbol moves the FSM to the matching polarity.
  - The FSM is updated by every nonzero symbol, including V and B.
  - The first pulse after reset (state NONE) is never a V.
- V detection: a nonzero symbol whose polarity equals the current FSM state (POS or NEG) is a V.
- Delay line: 4 mark bits, d0 (newest) to d3 (oldest).
  - Each edge shifts d3 into o_data and d2..d0 up one place, and the new mark enters d0.
  - On a V, the entering bit is forced to 0 and the 3 previous symbols are also cleared in the same edge (the values landing in d1..d3 = 0).
  - This clears both the 000V and the B00V patterns.
- Latency: the symbol sampled at edge k drives o_data after edge k+4. o_data is 0 for the first 4 cycles after reset release.
- o_v_det and o_code_err: asserted after edge k+1 for the symbol sampled at edge k. They are not aligned with o_data.
- Zero-run counter:
  - Increments on each zero symbol and clears on any nonzero symbol.
  - Saturates at ZERO_RUN_MAX+1.
  - Raises o_code_err once, when the count reaches ZERO_RUN_MAX+1, and not again until a nonzero symbol arrives.
- Last-V state, NONE / POS / NEG:
  - Updated on each V.
  - A V with the same polarity as the last V raises o_code_err.
  - The first V after reset is exempt.
  - Decoding is still performed.
- Simultaneous errors: multiple error causes in one symbol produce a single o_code_err pulse.
- Reset mid-stream clears all state immediately; partial substitutions are discarded, not output.

Decomposition:
- Shared package hdb3_pkg holds:
  - Symbol constants CODE_ZERO=2'b00, CODE_POS=2'b01, CODE_NEG=2'b10, CODE_ILL=2'b11. The encoder chain uses the same package.
  - A polarity enum {POL_NONE, POL_POS, POL_NEG}.
- One natural sub-module: hdb3_v_detect. It contains the polarity FSM, the last-V tracking and the zero-run/error logic, and outputs a per-symbol is_v / mark / err.
- The delay line and output register stay in hdb3_decode.

Test Plan:
- AMI, no substitution: symbols 01,10,01,10 → o_data 1,1,1,1 from edge 5 on; o_v_det and o_code_err stay 0.
- 000V: symbols 01,00,00,00,01 → o_data 1,0,0,0,0; o_v_det pulses once, one cycle after the 5th symbol.
- B00V: symbols 10,01,00,00,01 → o_data 1,0,0,0,0 (the B at position 2 is cleared); one o_v_det pulse.
- Code errors:
  - Symbol 11 mid-stream → decoded as 0; one o_code_err pulse.
  - Symbols 01,00,00,00,00 → o_code_err once, after the 4th zero.
- V alternation violation: 01,00,00,00,01,00,00,00,01 → two o_v_det pulses; o_code_err on the second V.
- Reset in the middle of a B00V: assert i_rst_n=0 after the 3rd symbol → all outputs 0 at once; after release, 4 cycles of o_data=0, then normal decoding.
